// File: rtl/dport_unstuff_if.sv
// ----------------------------------------------------------------------------
// dport_unstuff_if
//   Bundles the symbol stream entering the DisplayPort destuffer and the pixel /
//   framing / statistics signals leaving it.
//
// Handshake semantics (applies to every qualifier in this interface):
//   sym_valid   qualifies sym/isk for exactly the cycle it is high. There is no
//               ready: the destuffer consumes both symbols every valid cycle.
//   pixel_valid qualifies pixel_data for exactly the cycle it is high. There is
//               no backpressure: the consumer must take the pixel that cycle.
//   hstart/err  are single-cycle pulses. vblank, line_pixels and err_count are
//               levels.
//
// Signals
//   sym_valid    1   two symbols present this cycle
//   sym          16  [7:0] earlier symbol, [15:8] later symbol
//   isk          2   K flag per byte, bit i for byte i
//   pixel_valid  1   pixel_data valid
//   pixel_data   24  {R,G,B}, R is the first received byte
//   hstart       1   pulse when a line becomes active
//   vblank       1   VB-ID bit0 of the latest blanking period
//   err          1   framing error pulse
//   line_pixels  16  pixels in the last completed line
//   err_count    16  saturating count of cycles with an error
//
// Modports
//   master : symbol source / pixel sink (drives sym side, observes pixel side)
//   slave  : the destuffer
// ----------------------------------------------------------------------------
interface dport_unstuff_if;
  logic        sym_valid;
  logic [15:0] sym;
  logic [1:0]  isk;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic        hstart;
  logic        vblank;
  logic        err;
  logic [15:0] line_pixels;
  logic [15:0] err_count;

  modport master (
    output sym_valid, sym, isk,
    input  pixel_valid, pixel_data, hstart, vblank, err, line_pixels, err_count
  );

  modport slave (
    input  sym_valid, sym, isk,
    output pixel_valid, pixel_data, hstart, vblank, err, line_pixels, err_count
  );
endinterface

// File: rtl/dport_unstuff.sv
// ----------------------------------------------------------------------------
// dport_unstuff
//   Single-lane DisplayPort main-link destuffer (sink / loopback path). Takes
//   two descrambled 8b symbols per clock, follows the blanking / active / fill
//   framing, drops fill bytes and rebuilds 8bpc RGB pixels. Reports line start
//   (hstart), the VB-ID vertical blanking flag and framing errors.
//
// Optional feature macro: DPORT_UNSTUFF_STATS_EN
//   defined   : line_pixels and err_count statistics counters are built.
//   undefined : line_pixels and err_count are tied to 0; err still pulses.
//
// Ports
//   clk        in   symbol clock (dpclk domain)
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of dport_unstuff_if (symbol in, pixels/status out)
//   state_dbg  out  current framing state (0 BLANK, 1 ACTIVE, 2 FILL)
// ----------------------------------------------------------------------------
module dport_unstuff #(
  parameter logic [7:0] BS_SYM = 8'hBC,  // blanking start (K28.5)
  parameter logic [7:0] BE_SYM = 8'hFB,  // blanking end   (K27.7)
  parameter logic [7:0] FS_SYM = 8'hFE,  // fill start     (K30.7)
  parameter logic [7:0] FE_SYM = 8'hF7,  // fill end       (K23.7)
  parameter logic [7:0] SR_SYM = 8'h1C   // scrambler reset (K28.0), acts as BS
) (
  input  logic             clk,
  input  logic             rst_n,
  dport_unstuff_if.slave   bus,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FILL   = 2'd2
  } state_t;

  // Framing state and pixel accumulator
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;       // bytes of the current pixel held (0..2)
  logic [7:0]  acc_r_q, acc_r_d;
  logic [7:0]  acc_g_q, acc_g_d;
  logic        vb_pend_q, vb_pend_d; // next BLANK data byte is the VB-ID
  logic        vblank_q, vblank_d;

  // Per-cycle results of walking the two bytes
  logic        pix_hit;
  logic [23:0] pix_val;
  logic        hs_hit;
  logic        err_hit;

  // Registered outputs
  logic        pixel_valid_q;
  logic [23:0] pixel_data_q;
  logic        hstart_q;
  logic        err_q;

`ifdef DPORT_UNSTUFF_STATS_EN
  // Per-byte events handed to the statistics block so it can replay the
  // ordering inside a cycle (a pixel may complete just before a BS closes the
  // line, or a BS may close one line right before a BE opens the next).
  logic [1:0]  pix_at;
  logic [1:0]  close_at;
  logic [1:0]  open_at;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic: byte0 then byte1, each byte sees the state left by the
  // previous one.
  // --------------------------------------------------------------------------
  always_comb begin : framing_comb
    logic [7:0] b;
    logic       k;
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_r_d   = acc_r_q;
    acc_g_d   = acc_g_q;
    vb_pend_d = vb_pend_q;
    vblank_d  = vblank_q;
    pix_hit   = 1'b0;
    pix_val   = '0;
    hs_hit    = 1'b0;
    err_hit   = 1'b0;
    b         = '0;
    k         = 1'b0;
`ifdef DPORT_UNSTUFF_STATS_EN
    pix_at    = '0;
    close_at  = '0;
    open_at   = '0;
`endif
    if (bus.sym_valid) begin
      for (int i = 0; i < 2; i++) begin
        b = bus.sym[8*i +: 8];
        k = bus.isk[i];
        if (k) begin
          case (b)
            BS_SYM, SR_SYM: begin
              if (state_d != ST_BLANK) begin
                // Line closes even if a pixel was half-built; the fragment
                // is dropped and flagged.
                if (cnt_d != 2'd0) err_hit = 1'b1;
`ifdef DPORT_UNSTUFF_STATS_EN
                close_at[i] = 1'b1;
`endif
              end
              state_d   = ST_BLANK;
              cnt_d     = 2'd0;
              vb_pend_d = 1'b1;
            end
            BE_SYM: begin
              if (state_d == ST_BLANK) begin
                state_d   = ST_ACTIVE;
                hs_hit    = 1'b1;
                vb_pend_d = 1'b0;
`ifdef DPORT_UNSTUFF_STATS_EN
                open_at[i] = 1'b1;
`endif
              end else begin
                err_hit = 1'b1;
              end
            end
            FS_SYM: begin
              if (state_d == ST_ACTIVE) state_d = ST_FILL;
              else                      err_hit = 1'b1;
            end
            FE_SYM: begin
              if (state_d == ST_FILL) state_d = ST_ACTIVE;
              else                    err_hit = 1'b1;
            end
            default: begin
              // Unknown K: corrupt link, so any half pixel is untrustworthy.
              err_hit = 1'b1;
              if (state_d != ST_BLANK) cnt_d = 2'd0;
            end
          endcase
        end else begin
          case (state_d)
            ST_BLANK: begin
              if (vb_pend_d) begin
                vblank_d  = b[0];
                vb_pend_d = 1'b0;
              end
            end
            ST_ACTIVE: begin
              case (cnt_d)
                2'd0: begin
                  acc_r_d = b;
                  cnt_d   = 2'd1;
                end
                2'd1: begin
                  acc_g_d = b;
                  cnt_d   = 2'd2;
                end
                default: begin
                  pix_hit = 1'b1;
                  pix_val = {acc_r_d, acc_g_d, b};
                  cnt_d   = 2'd0;
`ifdef DPORT_UNSTUFF_STATS_EN
                  pix_at[i] = 1'b1;
`endif
                end
              endcase
            end
            default: begin
              // FILL: stuffing bytes carry no pixel data
            end
          endcase
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      cnt_q         <= 2'd0;
      acc_r_q       <= '0;
      acc_g_q       <= '0;
      vb_pend_q     <= 1'b0;
      vblank_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      hstart_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_r_q       <= acc_r_d;
      acc_g_q       <= acc_g_d;
      vb_pend_q     <= vb_pend_d;
      vblank_q      <= vblank_d;
      pixel_valid_q <= pix_hit;
      if (pix_hit) pixel_data_q <= pix_val;
      hstart_q      <= hs_hit;
      err_q         <= err_hit;
    end
  end

  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_data  = pixel_data_q;
  assign bus.hstart      = hstart_q;
  assign bus.vblank      = vblank_q;
  assign bus.err         = err_q;
  assign state_dbg       = state_q;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef DPORT_UNSTUFF_STATS_EN
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [15:0] line_pixels_q, line_pixels_d;
  logic [15:0] err_count_q;

  always_comb begin : stats_comb
    line_cnt_d    = line_cnt_q;
    line_pixels_d = line_pixels_q;
    for (int i = 0; i < 2; i++) begin
      if (open_at[i]) line_cnt_d = '0;
      if (pix_at[i] && (line_cnt_d != 16'hFFFF)) line_cnt_d = line_cnt_d + 16'd1;
      if (close_at[i]) line_pixels_d = line_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_q    <= '0;
      line_pixels_q <= '0;
      err_count_q   <= '0;
    end else begin
      line_cnt_q    <= line_cnt_d;
      line_pixels_q <= line_pixels_d;
      // One increment per erroneous cycle, however many bytes were bad.
      if (err_hit && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
    end
  end

  assign bus.line_pixels = line_pixels_q;
  assign bus.err_count   = err_count_q;
`else
  assign bus.line_pixels = '0;
  assign bus.err_count   = '0;
`endif

endmodule

// File: tb/tb_dport_unstuff.sv
// ----------------------------------------------------------------------------
// tb_dport_unstuff
//   Directed bench for dport_unstuff. Inputs change on the falling edge, the
//   DUT samples on the rising edge, outputs are checked 1 ns after it, so each
//   step's checks see the registered result of that step's symbols.
// ----------------------------------------------------------------------------
module tb_dport_unstuff;

  localparam logic [7:0] BS = 8'hBC;
  localparam logic [7:0] BE = 8'hFB;
  localparam logic [7:0] FS = 8'hFE;
  localparam logic [7:0] FE = 8'hF7;
  localparam logic [7:0] UK = 8'h3C;  // K28.1, not part of the framing set

`ifdef DPORT_UNSTUFF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dport_unstuff_if bus ();

  dport_unstuff dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stat(input logic [15:0] v);
    return STATS ? v : 16'h0000;
  endfunction

  // Expects a pixel this cycle: the value comes from the head of exp_q.
  task automatic chk_pix(input string tag);
    logic [23:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hDEAD00;
    chk({tag, "_pv"}, {31'd0, bus.pixel_valid}, 32'd1);
    chk({tag, "_data"}, {8'd0, bus.pixel_data}, {8'd0, e});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [7:0] b0, input logic k0,
                      input logic [7:0] b1, input logic k1);
    @(negedge clk);
    bus.sym_valid = v;
    bus.sym       = {b1, b0};
    bus.isk       = {k1, k0};
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    exp_q = '{24'h112233, 24'h445566, 24'hAABBCC, 24'h010203, 24'h102030,
              24'h556677, 24'h818283, 24'hA3A4A5, 24'hB1B2B3, 24'hC1C2C3};
    rst_n         = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym       = '0;
    bus.isk       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pv",     {31'd0, bus.pixel_valid}, 32'd0);
    chk("rst_data",   {8'd0, bus.pixel_data},   32'd0);
    chk("rst_hstart", {31'd0, bus.hstart},      32'd0);
    chk("rst_vblank", {31'd0, bus.vblank},      32'd0);
    chk("rst_err",    {31'd0, bus.err},         32'd0);
    chk("rst_lp",     {16'd0, bus.line_pixels}, 32'd0);
    chk("rst_ec",     {16'd0, bus.err_count},   32'd0);
    chk("rst_state",  {30'd0, state_dbg},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: BS, VB-ID=01, BE, six data bytes
    step(1'b1, BS, 1'b1, 8'h01, 1'b0);
    chk("t1_vblank", {31'd0, bus.vblank}, 32'd1);
    chk("t1_pv0",    {31'd0, bus.pixel_valid}, 32'd0);
    step(1'b1, BE, 1'b1, 8'h11, 1'b0);
    chk("t1_hstart", {31'd0, bus.hstart}, 32'd1);
    chk("t1_state",  {30'd0, state_dbg},  32'd1);
    chk("t1_pv1",    {31'd0, bus.pixel_valid}, 32'd0);
    step(1'b1, 8'h22, 1'b0, 8'h33, 1'b0);
    chk_pix("t1_px0");
    chk("t1_hs_off", {31'd0, bus.hstart}, 32'd0);
    step(1'b1, 8'h44, 1'b0, 8'h55, 1'b0);
    chk("t1_pv2",    {31'd0, bus.pixel_valid}, 32'd0);
    step(1'b1, 8'h66, 1'b0, 8'hAA, 1'b0);
    chk_pix("t1_px1");

    // 2: AA,BB, FS, 00,00, FE, CC
    step(1'b1, 8'hBB, 1'b0, FS, 1'b1);
    chk("t2_pv0",    {31'd0, bus.pixel_valid}, 32'd0);
    chk("t2_fill",   {30'd0, state_dbg},  32'd2);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("t2_pv1",    {31'd0, bus.pixel_valid}, 32'd0);
    step(1'b1, FE, 1'b1, 8'hCC, 1'b0);
    chk_pix("t2_px");
    chk("t2_err",    {31'd0, bus.err}, 32'd0);
    chk("t2_active", {30'd0, state_dbg}, 32'd1);

    // idle cycle carrying framing codes must be ignored
    step(1'b0, BS, 1'b1, BE, 1'b1);
    chk("idle_state", {30'd0, state_dbg}, 32'd1);
    chk("idle_pv",    {31'd0, bus.pixel_valid}, 32'd0);
    chk("idle_hs",    {31'd0, bus.hstart}, 32'd0);

    // 3: four data bytes then BS (line so far: 3 pixels)
    step(1'b1, 8'h01, 1'b0, 8'h02, 1'b0);
    chk("t3_pv0",    {31'd0, bus.pixel_valid}, 32'd0);
    step(1'b1, 8'h03, 1'b0, 8'h04, 1'b0);
    chk_pix("t3_px");
    step(1'b1, BS, 1'b1, 8'h07, 1'b0);
    chk("t3_err",    {31'd0, bus.err}, 32'd1);
    chk("t3_state",  {30'd0, state_dbg}, 32'd0);
    chk("t3_vblank", {31'd0, bus.vblank}, 32'd1);
    chk("t3_lp",     {16'd0, bus.line_pixels}, {16'd0, stat(16'd4)});
    chk("t3_ec",     {16'd0, bus.err_count},   {16'd0, stat(16'd1)});

    // 4: BE plus first byte in one cycle; pixel; BS + VB-ID=00 in one cycle
    step(1'b1, BE, 1'b1, 8'h10, 1'b0);
    chk("t4_hstart", {31'd0, bus.hstart}, 32'd1);
    chk("t4_err",    {31'd0, bus.err}, 32'd0);
    step(1'b1, 8'h20, 1'b0, 8'h30, 1'b0);
    chk_pix("t4_px0");
    step(1'b1, BS, 1'b1, 8'h00, 1'b0);
    chk("t4_vblank", {31'd0, bus.vblank}, 32'd0);
    chk("t4_state",  {30'd0, state_dbg}, 32'd0);
    chk("t4_noerr",  {31'd0, bus.err}, 32'd0);
    chk("t4_lp",     {16'd0, bus.line_pixels}, {16'd0, stat(16'd1)});
    step(1'b1, BE, 1'b1, 8'h55, 1'b0);
    chk("t4_hs2",    {31'd0, bus.hstart}, 32'd1);
    step(1'b1, 8'h66, 1'b0, 8'h77, 1'b0);
    chk_pix("t4_px1");
    step(1'b1, 8'h81, 1'b0, 8'h82, 1'b0);
    step(1'b1, 8'h83, 1'b0, BS, 1'b1);
    chk_pix("t4_px_bs");
    chk("t4_bs_noerr", {31'd0, bus.err}, 32'd0);
    chk("t4_lp2",    {16'd0, bus.line_pixels}, {16'd0, stat(16'd2)});
    step(1'b1, 8'h01, 1'b0, BE, 1'b1);
    chk("t4_vb_be",  {31'd0, bus.vblank}, 32'd1);
    chk("t4_hs3",    {31'd0, bus.hstart}, 32'd1);

    // 5: unknown K with two bytes held
    step(1'b1, 8'hA1, 1'b0, 8'hA2, 1'b0);
    chk("t5_pv0",    {31'd0, bus.pixel_valid}, 32'd0);
    step(1'b1, UK, 1'b1, 8'hA3, 1'b0);
    chk("t5_err",    {31'd0, bus.err}, 32'd1);
    chk("t5_pv1",    {31'd0, bus.pixel_valid}, 32'd0);
    chk("t5_state",  {30'd0, state_dbg}, 32'd1);
    chk("t5_ec",     {16'd0, bus.err_count}, {16'd0, stat(16'd2)});
    step(1'b1, 8'hA4, 1'b0, 8'hA5, 1'b0);
    chk_pix("t5_px");
    chk("t5_err_off", {31'd0, bus.err}, 32'd0);

    // two out-of-place codes in one cycle: one pulse, one count
    step(1'b1, FE, 1'b1, BE, 1'b1);
    chk("oop_err",   {31'd0, bus.err}, 32'd1);
    chk("oop_state", {30'd0, state_dbg}, 32'd1);
    chk("oop_ec",    {16'd0, bus.err_count}, {16'd0, stat(16'd3)});
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("oop_pulse", {31'd0, bus.err}, 32'd0);
    step(1'b1, FS, 1'b1, FE, 1'b1);
    chk("fsfe_err",  {31'd0, bus.err}, 32'd0);
    chk("fsfe_state", {30'd0, state_dbg}, 32'd1);

    // 6: reset mid-line with one byte held
    step(1'b1, 8'hB1, 1'b0, 8'hB2, 1'b0);
    step(1'b1, 8'hB3, 1'b0, 8'hB4, 1'b0);
    chk_pix("t6_px_pre");
    #2;
    rst_n         = 1'b0;
    bus.sym_valid = 1'b0;
    #1;
    chk("t6_pv",     {31'd0, bus.pixel_valid}, 32'd0);
    chk("t6_data",   {8'd0, bus.pixel_data},   32'd0);
    chk("t6_vblank", {31'd0, bus.vblank},      32'd0);
    chk("t6_state",  {30'd0, state_dbg},       32'd0);
    chk("t6_ec",     {16'd0, bus.err_count},   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h11, 1'b0, 8'h22, 1'b0);
    chk("t6_ign_pv", {31'd0, bus.pixel_valid}, 32'd0);
    chk("t6_ign_vb", {31'd0, bus.vblank}, 32'd0);
    step(1'b1, UK, 1'b1, 8'h01, 1'b0);
    chk("t6_uk_err", {31'd0, bus.err}, 32'd1);
    chk("t6_uk_vb",  {31'd0, bus.vblank}, 32'd0);
    chk("t6_uk_ec",  {16'd0, bus.err_count}, {16'd0, stat(16'd1)});
    step(1'b1, BS, 1'b1, 8'h01, 1'b0);
    chk("t6_vb",     {31'd0, bus.vblank}, 32'd1);
    step(1'b1, BE, 1'b1, 8'hC1, 1'b0);
    chk("t6_hs",     {31'd0, bus.hstart}, 32'd1);
    step(1'b1, 8'hC2, 1'b0, 8'hC3, 1'b0);
    chk_pix("t6_px");
    chk("t6_lp",     {16'd0, bus.line_pixels}, 32'd0);

    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
